shift_unit: RTL and testbench
=============================

// Module: shift_unit
// PURPOSE
//   Registered single-bit shift unit of the ALU datapath. Selects operand A or B,
//   shifts it logically by one position left or right per ALU_FUN, and registers
//   the result with a valid flag. Sits beside the arithmetic/logic units; the ALU
//   decoder drives shift_enable only when a shift op is selected.
// PARAMETERS
//   width  16  operand and result width in bits (>= 2)
// PORTS
//   clk           input   1      rising-edge clock
//   reset         input   1      reset, synchronous, active-low
//   A             input   width  operand A
//   B             input   width  operand B
//   ALU_FUN       input   2      shift op select
//   shift_enable  input   1      unit enable; 1 = perform shift this cycle
//   shift_out     output  width  registered shift result
//   shift_flag    output  1      registered valid flag for shift_out
// BEHAVIOUR
//   - All outputs are flops updated on posedge clk only; no combinational path to outputs.
//   - Reset: sampled at posedge clk with reset==0 -> shift_out=0, shift_flag=0.
//     Reset has priority over every other input. Reset mid-operation discards the op.
//     No asynchronous effect: outputs change only at the clock edge.
//   - reset==1, shift_enable==1: shift_flag<=1, shift_out<= by ALU_FUN:
//       2'b00  A logical shift right 1: {1'b0, A[width-1:1]}
//       2'b01  A logical shift left 1:  {A[width-2:0], 1'b0}
//       2'b10  B logical shift right 1: {1'b0, B[width-1:1]}
//       2'b11  B logical shift left 1:  {B[width-2:0], 1'b0}
//     Shifted-out bit is discarded; vacated bit is always 0 (no sign extension, no carry).
//   - ALU_FUN containing X/Z with enable=1: shift_out<=0, shift_flag<=0.
//   - reset==1, shift_enable==0: shift_out<=0, shift_flag<=0 (cleared, not held).
//   - Latency: inputs stable before posedge N appear on outputs after posedge N
//     (one cycle). Throughput one op per cycle, no handshake, no back-pressure.
//   - Each cycle is independent; no internal state beyond the output registers.
// TESTING
//   - Reset: reset=0 over one posedge, any inputs -> shift_out=16'h0000, shift_flag=0.
//   - SRL A: reset=1, en=1, ALU_FUN=00, A=16'h8001 -> next cycle shift_out=16'h4000, flag=1.
//   - SLL A: en=1, ALU_FUN=01, A=16'h8001 -> shift_out=16'h0002, flag=1 (MSB dropped).
//   - B ops: B=16'hFFFF, ALU_FUN=10 -> 16'h7FFF; ALU_FUN=11 -> 16'hFFFE; flag=1 both.
//   - Disable: after a valid op, en=0 with A=16'h1234 -> shift_out=16'h0000, flag=0.
//   - Random: 100 negedge-applied vectors (A,B,ALU_FUN,en random, reset=1), compare
//     against the table above one posedge later with !==; report pass/fail counts, 0 errors.

Source files
------------

// File: rtl/shift_unit.sv
// Registered one-bit logical shift unit: shifts operand A or B left or right by one position.
// Latency: one cycle from input sample at posedge clk to registered outputs; one op per cycle.
// Backpressure: none; no handshake, and results are always accepted downstream.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset; outputs cleared, has priority over everything
//   A, B         width-bit operands
//   ALU_FUN      op select: 00 A>>1, 01 A<<1, 10 B>>1, 11 B<<1
//   shift_enable 1 = perform the selected shift this cycle; 0 = clear outputs
//   shift_out    registered shift result
//   shift_flag   registered valid flag for shift_out
module shift_unit #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic [1:0]       ALU_FUN,
  input  logic             shift_enable,
  output logic [width-1:0] shift_out,
  output logic             shift_flag
);

  logic [width-1:0] shift_out_d, shift_out_q;
  logic             shift_flag_d, shift_flag_q;

  // Next-state result. The default arm also catches an unknown ALU_FUN,
  // which then yields a cleared, invalid result rather than a guess.
  always_comb begin
    shift_out_d  = '0;
    shift_flag_d = 1'b0;
    if (shift_enable) begin
      case (ALU_FUN)
        2'b00: begin
          shift_out_d  = {1'b0, A[width-1:1]};
          shift_flag_d = 1'b1;
        end
        2'b01: begin
          shift_out_d  = {A[width-2:0], 1'b0};
          shift_flag_d = 1'b1;
        end
        2'b10: begin
          shift_out_d  = {1'b0, B[width-1:1]};
          shift_flag_d = 1'b1;
        end
        2'b11: begin
          shift_out_d  = {B[width-2:0], 1'b0};
          shift_flag_d = 1'b1;
        end
        default: begin
          shift_out_d  = '0;
          shift_flag_d = 1'b0;
        end
      endcase
    end
  end

  // Outputs are cleared (not held) whenever the unit is idle, so the
  // only state is this output register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_out_q  <= '0;
      shift_flag_q <= 1'b0;
    end else begin
      shift_out_q  <= shift_out_d;
      shift_flag_q <= shift_flag_d;
    end
  end

  assign shift_out  = shift_out_q;
  assign shift_flag = shift_flag_q;

endmodule

// File: tb/tb_shift_unit.sv
// Testbench for shift_unit: directed vectors with fixed expected values, then
// random vectors checked against an arithmetic reference model via a scoreboard.
module tb_shift_unit;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [1:0]   ALU_FUN;
  logic         shift_enable;
  logic [W-1:0] shift_out;
  logic         shift_flag;

  typedef struct {
    logic [W-1:0] out;
    logic         flag;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  shift_unit #(.width(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .A            (A),
    .B            (B),
    .ALU_FUN      (ALU_FUN),
    .shift_enable (shift_enable),
    .shift_out    (shift_out),
    .shift_flag   (shift_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pick operand, then halve (right) or double modulo 2^W (left).
  function automatic exp_t model(input bit rst_n, input bit en, input bit [1:0] fun,
                                 input bit [W-1:0] a, input bit [W-1:0] b);
    exp_t        e;
    int unsigned op;
    int unsigned r;
    e.name = "rand";
    if (!rst_n || !en) begin
      e.out  = '0;
      e.flag = 1'b0;
    end else begin
      op = fun[1] ? int'(b) : int'(a);
      if (fun[0]) r = (op * 2) % (1 << W);
      else        r = op / 2;
      e.out  = r[W-1:0];
      e.flag = 1'b1;
    end
    return e;
  endfunction

  // Apply one vector on the falling edge and queue what must appear after the next rising edge.
  task automatic drive(input bit rst_n, input bit en, input bit [1:0] fun,
                       input bit [W-1:0] a, input bit [W-1:0] b,
                       input bit [W-1:0] exp_out, input bit exp_flag, input string name);
    exp_t e;
    @(negedge clk);
    reset        = rst_n;
    shift_enable = en;
    ALU_FUN      = fun;
    A            = a;
    B            = b;
    e.out  = exp_out;
    e.flag = exp_flag;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic drive_rand();
    bit [W-1:0] a;
    bit [W-1:0] b;
    bit [1:0]   fun;
    bit         en;
    exp_t       e;
    a   = W'($urandom);
    b   = W'($urandom);
    fun = 2'($urandom_range(0, 3));
    en  = ($urandom_range(0, 3) != 0);
    e   = model(1'b1, en, fun, a, b);
    drive(1'b1, en, fun, a, b, e.out, e.flag, "rand");
  endtask

  // Monitor: outputs are valid every cycle, so compare one entry per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (shift_out !== e.out) begin
          errors++;
          $display("FAIL %s shift_out got %h expected %h", e.name, shift_out, e.out);
        end
        checks++;
        if (shift_flag !== e.flag) begin
          errors++;
          $display("FAIL %s shift_flag got %b expected %b", e.name, shift_flag, e.flag);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    reset        = 1'b0;
    shift_enable = 1'b0;
    ALU_FUN      = 2'b00;
    A            = '0;
    B            = '0;

    // Reset with an active op on the inputs must still clear.
    drive(1'b0, 1'b1, 2'b01, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, "reset");
    drive(1'b1, 1'b1, 2'b00, 16'h8001, 16'h0000, 16'h4000, 1'b1, "srl_a");
    drive(1'b1, 1'b1, 2'b01, 16'h8001, 16'h0000, 16'h0002, 1'b1, "sll_a");
    drive(1'b1, 1'b1, 2'b10, 16'h0000, 16'hFFFF, 16'h7FFF, 1'b1, "srl_b");
    drive(1'b1, 1'b1, 2'b11, 16'h0000, 16'hFFFF, 16'hFFFE, 1'b1, "sll_b");
    drive(1'b1, 1'b0, 2'b01, 16'h1234, 16'h0000, 16'h0000, 1'b0, "disable");
    // Operand select: A and B differ so a swapped mux is visible.
    drive(1'b1, 1'b1, 2'b01, 16'h0001, 16'h4000, 16'h0002, 1'b1, "sel_a");
    drive(1'b1, 1'b1, 2'b11, 16'h0001, 16'h4000, 16'h8000, 1'b1, "sel_b");
    // Reset arriving mid-stream discards the op presented with it.
    drive(1'b1, 1'b1, 2'b10, 16'h0000, 16'hAAAA, 16'h5555, 1'b1, "pre_rst");
    drive(1'b0, 1'b1, 2'b10, 16'h0000, 16'hAAAA, 16'h0000, 1'b0, "mid_rst");

    for (int i = 0; i < 100; i++) drive_rand();

    // Let the scoreboard drain, bounded.
    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain %0d entries left expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
